// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data-memory port, load alignment/extension, store byte enables.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).

package mem_stage_pkg;
    localparam int RegWidth = 32;

    typedef struct packed {
        logic       valid;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic [2:0] func3;
    } ctrl_t;

    typedef struct packed {
        logic [4:0]          addr;
        logic [RegWidth-1:0] value;
    } reg_t;

    typedef struct packed {
        ctrl_t ctrl;
        reg_t  rd;
        reg_t  rs;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t ctrl;
        reg_t  rd;
    } mem_wb_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iFlush,
    input  ex_mem_t             iEX,
    output mem_wb_t             oWB,
    output logic [RegWidth-1:0] oFwMe,
    output logic                oStall,
    output logic                oDmReq,
    output logic                oDmWe,
    output logic [31:0]         oDmAddr,
    output logic [3:0]          oDmBe,
    output logic [31:0]         oDmWdata,
    input  logic                iDmAck,
    input  logic [31:0]         iDmRdata,
    input  logic                iDmErr,
    output logic                oFault,
    output logic [1:0]          oFaultCause
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    mem_wb_t       wb_q, wb_d;
    logic          req_q, req_d, we_q, we_d, drop_q, drop_d, fault_q, fault_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [1:0]    cause_q, cause_d;
    logic [2:0]    f3_q, f3_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [4:0]    rdAddr_q, rdAddr_d;

    logic          memop, isStore, illegal, misaligned, timeout;
    logic [2:0]    f3;
    logic [1:0]    off;
    logic [3:0]    reqBe;
    logic [31:0]   reqWdata, loadData;
    logic [7:0]    ldByte;
    logic [15:0]   ldHalf;

    assign memop   = iEX.ctrl.valid & (iEX.ctrl.mem_rd | iEX.ctrl.mem_wr);
    assign isStore = iEX.ctrl.mem_wr;
    assign f3      = iEX.ctrl.func3;
    assign off     = iEX.rd.value[1:0];

    always_comb begin
        illegal = isStore ? (f3 >= 3'b011)
                          : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        case (f3[1:0])
            2'b00: begin
                reqBe    = 4'b0001 << off;
                reqWdata = {4{iEX.rs.value[7:0]}};
            end
            2'b01: begin
                reqBe    = off[1] ? 4'b1100 : 4'b0011;
                reqWdata = {2{iEX.rs.value[15:0]}};
            end
            default: begin
                reqBe    = 4'b1111;
                reqWdata = iEX.rs.value;
            end
        endcase
    end

    // Lane selection uses the address latched at accept, not the live upstream value.
    always_comb begin
        ldByte = 8'(iDmRdata >> {addr_q[1:0], 3'b000});
        ldHalf = addr_q[1] ? iDmRdata[31:16] : iDmRdata[15:0];
        case (f3_q)
            3'b000:  loadData = {{24{ldByte[7]}}, ldByte};
            3'b001:  loadData = {{16{ldHalf[15]}}, ldHalf};
            3'b100:  loadData = {24'h0, ldByte};
            3'b101:  loadData = {16'h0, ldHalf};
            default: loadData = iDmRdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == BUSY) && !iDmAck && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (state_q == BUSY && state_d == BUSY) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (memop && !illegal && !misaligned && !iFlush) state_d = BUSY;
            BUSY:    if (iDmAck || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oStall   = 1'b0;
        wb_d     = '0;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        ctrl_d   = ctrl_q;
        rdAddr_d = rdAddr_q;
        drop_d   = drop_q;
        fault_d  = 1'b0;
        cause_d  = 2'b00;
        case (state_q)
            IDLE: begin
                if (iFlush) begin
                    wb_d = '0;
                end else if (!memop) begin
                    wb_d.ctrl = iEX.ctrl;
                    wb_d.rd   = iEX.rd;
                end else if (illegal || misaligned) begin
                    fault_d = 1'b1;
                    cause_d = 2'b01;
                end else begin
                    oStall   = 1'b1;
                    req_d    = 1'b1;
                    we_d     = isStore;
                    addr_d   = iEX.rd.value;
                    be_d     = reqBe;
                    wdata_d  = isStore ? reqWdata : 32'h0;
                    f3_d     = f3;
                    ctrl_d   = iEX.ctrl;
                    rdAddr_d = iEX.rd.addr;
                    drop_d   = 1'b0;
                end
            end
            BUSY: begin
                oStall = !iDmAck && !timeout;
                drop_d = drop_q | iFlush;
                if (iDmAck || timeout) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                    drop_d  = 1'b0;
                end
                if (iDmAck) begin
                    if (drop_q || iFlush) begin
                        wb_d = '0;
                    end else if (iDmErr) begin
                        fault_d = 1'b1;
                        cause_d = 2'b10;
                    end else begin
                        wb_d.ctrl     = ctrl_q;
                        wb_d.rd.addr  = rdAddr_q;
                        wb_d.rd.value = we_q ? '0 : loadData;
                        if (we_q) wb_d.ctrl.reg_wr = 1'b0;
                    end
                end else if (timeout) begin
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            wb_q     <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            ctrl_q   <= '0;
            rdAddr_q <= '0;
            drop_q   <= 1'b0;
            fault_q  <= 1'b0;
            cause_q  <= 2'b00;
        end else begin
            wb_q     <= wb_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            f3_q     <= f3_d;
            ctrl_q   <= ctrl_d;
            rdAddr_q <= rdAddr_d;
            drop_q   <= drop_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
        end
    end

    assign oWB         = wb_q;
    assign oFwMe       = wb_q.ctrl.valid ? wb_q.rd.value : '0;
    assign oDmReq      = req_q;
    assign oDmWe       = we_q;
    assign oDmAddr     = addr_q;
    assign oDmBe       = be_q;
    assign oDmWdata    = wdata_q;
    assign oFault      = fault_q;
    assign oFaultCause = cause_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expected values are hand-computed from the stage's behaviour.

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                iClk = 1'b0;
    logic                nRst;
    logic                iFlush;
    ex_mem_t             iEX;
    mem_wb_t             oWB;
    logic [RegWidth-1:0] oFwMe;
    logic                oStall, oDmReq, oDmWe, iDmAck, iDmErr, oFault;
    logic [31:0]         oDmAddr, oDmWdata, iDmRdata;
    logic [3:0]          oDmBe;
    logic [1:0]          oFaultCause;

    int checks = 0;
    int passed = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .iClk(iClk), .nRst(nRst), .iFlush(iFlush), .iEX(iEX), .oWB(oWB), .oFwMe(oFwMe),
        .oStall(oStall), .oDmReq(oDmReq), .oDmWe(oDmWe), .oDmAddr(oDmAddr), .oDmBe(oDmBe),
        .oDmWdata(oDmWdata), .iDmAck(iDmAck), .iDmRdata(iDmRdata), .iDmErr(iDmErr),
        .oFault(oFault), .oFaultCause(oFaultCause)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data);
        iEX               = '0;
        iEX.ctrl.valid    = valid;
        iEX.ctrl.mem_rd   = rd;
        iEX.ctrl.mem_wr   = wr;
        iEX.ctrl.reg_wr   = 1'b1;
        iEX.ctrl.func3    = f3;
        iEX.rd.addr       = 5'd7;
        iEX.rd.value      = addr;
        iEX.rs.value      = data;
    endtask

    task automatic idleInput();
        iEX    = '0;
        iDmAck = 1'b0;
        iDmErr = 1'b0;
    endtask

    // Issue a load, ack in the first BUSY cycle, and check the extended result.
    task automatic loadCase(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b1, 1'b0, f3, addr, 32'h0);
        #1 checkOutput({tag, "_stall_accept"}, 32'(oStall), 32'd1);
        tick();
        checkOutput({tag, "_req"}, 32'(oDmReq), 32'd1);
        checkOutput({tag, "_addr"}, oDmAddr, addr);
        iDmAck = 1'b1;
        iDmRdata = rdata;
        #1 checkOutput({tag, "_stall_ack"}, 32'(oStall), 32'd0);
        tick();
        idleInput();
        checkOutput({tag, "_valid"}, 32'(oWB.ctrl.valid), 32'd1);
        checkOutput({tag, "_value"}, oWB.rd.value, expected);
        checkOutput({tag, "_fw"}, oFwMe, expected);
        checkOutput({tag, "_req_low"}, 32'(oDmReq), 32'd0);
    endtask

    task automatic storeCase(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] expBe, input logic [31:0] expWdata);
        applyStimulus(1'b1, 1'b0, 1'b1, f3, addr, data);
        tick();
        checkOutput({tag, "_we"}, 32'(oDmWe), 32'd1);
        checkOutput({tag, "_be"}, 32'(oDmBe), 32'(expBe));
        checkOutput({tag, "_wdata"}, oDmWdata, expWdata);
        iDmAck = 1'b1;
        tick();
        idleInput();
        checkOutput({tag, "_valid"}, 32'(oWB.ctrl.valid), 32'd1);
        checkOutput({tag, "_regwr"}, 32'(oWB.ctrl.reg_wr), 32'd0);
    endtask

    task automatic faultCase(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr);
        applyStimulus(1'b1, rd, wr, f3, addr, 32'h0);
        #1 checkOutput({tag, "_stall"}, 32'(oStall), 32'd0);
        tick();
        idleInput();
        checkOutput({tag, "_req"}, 32'(oDmReq), 32'd0);
        checkOutput({tag, "_fault"}, 32'(oFault), 32'd1);
        checkOutput({tag, "_cause"}, 32'(oFaultCause), 32'd1);
        checkOutput({tag, "_bubble"}, 32'(oWB.ctrl.valid), 32'd0);
        tick();
        checkOutput({tag, "_pulse_end"}, 32'(oFault), 32'd0);
    endtask

    initial begin
        nRst = 1'b0;
        iFlush = 1'b0;
        iDmRdata = '0;
        idleInput();
        #12;
        checkOutput("rst_valid", 32'(oWB.ctrl.valid), 32'd0);
        checkOutput("rst_req", 32'(oDmReq), 32'd0);
        checkOutput("rst_fault", 32'(oFault), 32'd0);
        checkOutput("rst_fw", oFwMe, 32'd0);
        checkOutput("rst_stall", 32'(oStall), 32'd0);
        nRst = 1'b1;
        tick();

        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0);
        #1 checkOutput("alu_stall", 32'(oStall), 32'd0);
        tick();
        idleInput();
        checkOutput("alu_valid", 32'(oWB.ctrl.valid), 32'd1);
        checkOutput("alu_value", oWB.rd.value, 32'h0000_1234);
        checkOutput("alu_rdaddr", 32'(oWB.rd.addr), 32'd7);
        checkOutput("alu_fw", oFwMe, 32'h0000_1234);

        loadCase("lb",  3'b000, 32'h0000_1003, 32'h80FF_FF00, 32'hFFFF_FF80);
        loadCase("lbu", 3'b100, 32'h0000_1003, 32'h80FF_FF00, 32'h0000_0080);
        loadCase("lh",  3'b001, 32'h0000_0002, 32'h8001_7FFF, 32'hFFFF_8001);
        loadCase("lhu", 3'b101, 32'h0000_0002, 32'h8001_7FFF, 32'h0000_8001);
        loadCase("lb0", 3'b000, 32'h0000_0000, 32'h1234_567F, 32'h0000_007F);

        storeCase("sh", 3'b001, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        storeCase("sb", 3'b000, 32'h0000_2001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        storeCase("sw", 3'b010, 32'h0000_2004, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);

        faultCase("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_3001);
        faultCase("sh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_3003);
        faultCase("ld_ill", 1'b1, 1'b0, 3'b011, 32'h0000_3000);
        faultCase("st_ill", 1'b0, 1'b1, 3'b100, 32'h0000_3000);

        // Slow ack: three extra BUSY cycles before the ack arrives.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0);
        #1 checkOutput("slow_stall0", 32'(oStall), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("slow_stall", 32'(oStall), 32'd1);
            checkOutput("slow_req", 32'(oDmReq), 32'd1);
            checkOutput("slow_addr", oDmAddr, 32'h0000_3000);
            checkOutput("slow_bubble", 32'(oWB.ctrl.valid), 32'd0);
            tick();
        end
        iDmAck = 1'b1;
        iDmRdata = 32'hDEAD_BEEF;
        #1 checkOutput("slow_stall_ack", 32'(oStall), 32'd0);
        tick();
        idleInput();
        checkOutput("slow_valid", 32'(oWB.ctrl.valid), 32'd1);
        checkOutput("slow_value", oWB.rd.value, 32'hDEAD_BEEF);

        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
        tick();
        iDmAck = 1'b1;
        iDmErr = 1'b1;
        tick();
        idleInput();
        checkOutput("err_fault", 32'(oFault), 32'd1);
        checkOutput("err_cause", 32'(oFaultCause), 32'd2);
        checkOutput("err_bubble", 32'(oWB.ctrl.valid), 32'd0);

        // Flush one cycle into BUSY: transaction completes but the result is dropped.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0);
        tick();
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        checkOutput("fl_req_held", 32'(oDmReq), 32'd1);
        tick();
        iDmAck = 1'b1;
        iDmRdata = 32'h1111_2222;
        #1 checkOutput("fl_stall_ack", 32'(oStall), 32'd0);
        tick();
        idleInput();
        checkOutput("fl_bubble", 32'(oWB.ctrl.valid), 32'd0);
        checkOutput("fl_nofault", 32'(oFault), 32'd0);
        checkOutput("fl_req_low", 32'(oDmReq), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
        iFlush = 1'b1;
        #1 checkOutput("fli_stall", 32'(oStall), 32'd0);
        tick();
        iFlush = 1'b0;
        idleInput();
        checkOutput("fli_req", 32'(oDmReq), 32'd0);
        checkOutput("fli_bubble", 32'(oWB.ctrl.valid), 32'd0);

`ifdef MEM_TIMEOUT_EN
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_req", 32'(oDmReq), 32'd1);
            checkOutput("to_stall", 32'(oStall), (i == 3) ? 32'd0 : 32'd1);
            tick();
        end
        idleInput();
        checkOutput("to_req_low", 32'(oDmReq), 32'd0);
        checkOutput("to_fault", 32'(oFault), 32'd1);
        checkOutput("to_cause", 32'(oFaultCause), 32'd3);
`endif

        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; consumes the ex_mem_t register produced by the execute stage and produces the registered mem_wb_t for writeback.
- Issues load/store transactions on a req/ack data-memory port, aligns and extends load data, and generates store byte enables.
- Stalls the upstream pipeline while a transaction is outstanding and drives the MEM→EX forwarding value.

Parameters:
- TIMEOUT_CYCLES, 64, bus watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- iClk  input  1  clock.
- nRst  input  1  reset, asynchronous, active-low.
- iFlush  input  1  squash instruction currently in stage.
- iEX  input  ex_mem_t  upstream register. Fields used: ctrl.valid, ctrl.mem_rd, ctrl.mem_wr, ctrl.func3, rd.addr, rd.value (effective address or ALU result), rs.value (store data).
- oWB  output  mem_wb_t  registered writeback: ctrl, rd.addr, rd.value.
- oFwMe  output  RegWidth  equals oWB.rd.value when oWB.ctrl.valid, else 0.
- oStall  output  1  combinational; holds upstream stages.
- oDmReq  output  1  bus request.
- oDmWe  output  1  1 = store.
- oDmAddr  output  32  byte address.
- oDmBe  output  4  byte enables.
- oDmWdata  output  32  store data, lane-replicated.
- iDmAck  input  1  transaction complete; meaningful only while oDmReq=1.
- iDmRdata  input  32  load data, valid with iDmAck.
- iDmErr  input  1  bus error, valid with iDmAck.
- oFault  output  1  one-cycle fault pulse.
- oFaultCause  output  2  01 misaligned/illegal func3, 10 bus error, 11 timeout.

Behaviour:
- Reset: oWB='0, oDmReq=0, oDmWe=0, oDmAddr=0, oDmBe=0, oDmWdata=0, oFault=0, oFaultCause=0, state IDLE, drop flag 0.
- FSM states: IDLE, BUSY.
- memop = iEX.ctrl.valid & (mem_rd | mem_wr).
- IDLE, !memop: oWB <= iEX pass-through with rd.value unchanged. Latency 1 cycle; oStall=0.
- IDLE, memop, legal and aligned, !iFlush:
  - Latch addr, we, be, wdata, func3, addr[1:0] into request registers; go to BUSY.
  - oStall=1 this cycle; oWB.ctrl.valid <= 0 (bubble).
- BUSY: oDmReq=1 and bus outputs held stable until iDmAck.
  - oStall = !iDmAck.
  - On ack: go to IDLE; oWB loaded with result (store: ctrl.valid kept, rd write disabled via ctrl); oDmReq low next cycle.
  - Without ack: oWB bubble.
- Minimum load/store latency: 2 cycles (accept + ack).
- Alignment:
  - LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - Load func3 ∈ {011,110,111} or store func3 ≥ 011 is illegal.
  - Violation: no bus request, oFault=1, cause 01, oWB bubble, oStall=0.
- Store BE:
  - SB: 1<<addr[1:0].
  - SH: 0011 if addr[1]=0, else 1100.
  - SW: 1111.
  - Wdata: byte replicated ×4, half replicated ×2, or word as-is.
- Load extract: select byte/half lane by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- iDmErr with ack: oFault=1, cause 10, oWB bubble.
- iFlush in IDLE: no request issued, oWB bubble.
- iFlush in BUSY: transaction is not cancelled; request held until ack; drop flag set. On ack, result discarded (bubble), no fault raised, oStall released.
- Reset mid-transaction: immediate return to IDLE with oDmReq=0. The bus is expected to be reset concurrently.
- oFault/oFaultCause are registered; pulse asserts in the cycle after the event.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in BUSY and clears on IDLE entry.
  - Reaching TIMEOUT_CYCLES without ack: oDmReq drops, state → IDLE, oFault=1 with cause 11, oWB bubble, oStall released.
  - A late ack arriving while oDmReq=0 is ignored.
- Undefined: no counter; BUSY waits indefinitely; cause 11 is never produced.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_FF00, ack next cycle → oDmBe irrelevant for load, oWB.rd.value=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH, addr 0x2002, rs.value 0x0000_BEEF → oDmBe=1100, oDmWdata=0xBEEF_BEEF, oDmWe=1.
- LW, addr 0x3001 → no oDmReq, oFault pulse with cause 01, oWB.ctrl.valid=0.
- LW with ack delayed 3 cycles → oStall high 4 cycles, bus outputs constant, oWB valid one cycle after ack.
- Flush asserted 1 cycle into BUSY, ack 2 cycles later → oWB bubble, no fault, oStall low after ack.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → oDmReq low after 4 BUSY cycles, cause 11.
